pulse_encoder: RTL and testbench
================================

# pulse_encoder

- Inverse of the 2-to-4 decoder: collects event pulses on four request lines and serialises them into one address/enable transaction per event.
- Output is `addr1:addr0` plus `enable`, shaped to drive the decoder directly.
- Sits between event sources (status lines, interrupt-style strobes) and any consumer that takes an encoded 2-bit address.
- Pulses are counted per line, so back-to-back events are not lost while the consumer stalls.

## Interface
Parameters:
- `CNT_W`, default 3: width of each per-line pending counter; saturates at 2^CNT_W−1 (7 by default).

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`..`req3`  in  1 each  event pulse per line; each high cycle counts as one event.
- `ready`  in  1  consumer accepts the current transaction this cycle.
- `addr0`, `addr1`  out  1 each  encoded index of the line being served (`addr1` is MSB).
- `enable`  out  1  transaction valid; `addr` is meaningful only while high.
- `ovf`  out  1  sticky flag: at least one event was dropped on a saturated counter.

## Operation
- **Counters:** four `CNT_W`-bit counters, `cnt0`..`cnt3`.
  - `reqN` high at an edge increments `cntN`.
  - Loading line N into the output decrements `cntN`.
  - Increment and decrement on the same edge: `cntN` unchanged.
  - Increment while `cntN` is at max and no decrement on that edge: event dropped, `cntN` stays at max, `ovf` set to 1.
- **Overflow flag:** `ovf` clears only on reset.
- **States:**
  - IDLE: `enable`=0.
  - HOLD: `enable`=1; `addr` is stable and must not change until accepted.
- **Transitions:**
  - IDLE → HOLD: any counter nonzero (pre-edge values). Load the winner into `addr`, decrement its counter.
  - HOLD with `ready`=0: stay; outputs frozen.
  - HOLD with `ready`=1, another counter nonzero (pre-edge values, after discounting the decrement already taken): load the next winner in the same edge (back-to-back, no bubble).
  - HOLD with `ready`=1, no counter nonzero: go to IDLE, `enable`←0.
- **Winner selection:** uses pre-edge counter values. Pulses arriving on an edge are never selected on that same edge.
- **Round-robin arbitration** (see Configuration):
  - Search starts at (last granted index + 1) mod 4, wrapping 3→0.
  - The pointer updates on every load.
- **Reset values, applied immediately on `rst_n` low, mid-transaction included:**
  - All counters 0, state IDLE, `enable`=0, `addr1:addr0`=00, `ovf`=0.
  - Round-robin pointer = 3, so line 0 has first priority.
  - Pending events and any in-flight transaction are discarded.

## Timing
- **Latency:** pulse sampled at edge E1 → counter nonzero after E1 → `enable`=1 with valid `addr` after E2. Two edges from an idle block.
- **Throughput:** one transaction per cycle while `ready` is held high and events are pending.
- **Handshake:** a transfer completes on an edge where `enable`=1 and `ready`=1.
  - `ready` while `enable`=0 has no effect.
  - `ready` may be high before `enable`; there is no dependence in the other direction.
- **Output registering:** all outputs come straight from flops; no combinational path from any input to any output.

## Configuration
- **Macro:** `PULSE_ENCODER_RR_EN`.
- **Defined:** round-robin arbitration as above; the 2-bit last-grant pointer is present.
- **Undefined:**
  - Fixed priority: lowest-index nonzero counter always wins.
  - Pointer flops removed.
  - Under continuous traffic on line 0, higher lines may starve; this is accepted behaviour.
- All other behaviour is identical in both builds.

## Structure
- **Shared package** (`pulse_encoder_pkg`):
  - State encoding constants `ST_IDLE`, `ST_HOLD`.
  - Line count constant `NUM_LINES` = 4.
  - Index type (2-bit) shared with the decoder side.
- **Sub-module:** `pulse_counter`, one instance per line. It holds the saturating up/down counter, its nonzero flag, and a drop pulse that feeds the `ovf` OR.
- **Top level:** arbiter, FSM and output register.

## Test plan
- **Reset:** hold `rst_n`=0, toggle all `reqN` → `enable`=0, `addr`=00, `ovf`=0. Release, no pulses → stays idle.
- **Single pulse:** `req2` for one cycle, `ready`=1 → `enable`=1 with `addr`=10 exactly two edges later, for one cycle, then `enable`=0.
- **Round robin** (macro on): pulse `req0`..`req3` together three times, `ready`=1 → 12 transactions with addresses 0,1,2,3 repeated, no bubbles.
  - Macro off, same stimulus → 0,0,0,1,1,1,2,2,2,3,3,3.
- **Stall and saturation:** `ready`=0, ten pulses on `req1` → `ovf`=1 and `addr` frozen at 01.
  - Then `ready`=1 → exactly 8 transactions on line 1: the one loaded at the first pulse plus 7 counted.
- **Simultaneous events:** `req3` pulsing every cycle with `ready`=1 → `cnt3` holds steady, continuous `enable`=1, `addr`=11, no `ovf`.
- **Reset mid-operation:** assert `rst_n` low while in HOLD with counters nonzero → `enable` drops immediately. After release, no stale transactions appear.

Source files
------------

// File: rtl/pulse_encoder_pkg.sv
// Shared types and helpers for the pulse encoder and the 2-to-4 decoder it feeds.
// Holds state encoding, line count, the 2-bit index type and the arbitration search.
package pulse_encoder_pkg;

    localparam int NUM_LINES = 4;

    typedef logic [1:0] idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Scan the lines starting at start_idx, wrapping 3->0; first nonzero line wins.
    function automatic idx_t pick_winner(input logic [NUM_LINES-1:0] nz, input idx_t start_idx);
        idx_t win;
        idx_t cand;
        logic found;
        win   = start_idx;
        found = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            cand = start_idx + idx_t'(i);
            if (!found && nz[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/pulse_encoder_if.sv
// Event/transaction bus between event sources, the pulse encoder and its consumer.
// master = encoder side, slave = source/consumer side.
interface pulse_encoder_if;

    logic req0;
    logic req1;
    logic req2;
    logic req3;
    logic ready;
    logic addr0;
    logic addr1;
    logic enable;
    logic ovf;

    modport master (
        input  req0, req1, req2, req3, ready,
        output addr0, addr1, enable, ovf
    );

    modport slave (
        output req0, req1, req2, req3, ready,
        input  addr0, addr1, enable, ovf
    );

endinterface

// File: rtl/pulse_counter.sv
// Saturating per-line pending-event counter with nonzero flag and a drop pulse
// raised when an event arrives on a full counter that is not being drained.
module pulse_counter #(
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output logic nonzero_o,
    output logic drop_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = &cnt_q;

    always_comb begin
        cnt_d  = cnt_q;
        drop_o = 1'b0;
        case ({inc_i, dec_i})
            2'b10: begin
                if (at_max) begin
                    drop_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            2'b01: begin
                // The arbiter only drains nonzero lines; guard anyway against wrap.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/pulse_encoder.sv
// Serialises per-line event pulses into addr/enable transactions for a 2-to-4 decoder.
// Define PULSE_ENCODER_RR_EN for round-robin arbitration; otherwise fixed priority (line 0 first).
module pulse_encoder
    import pulse_encoder_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pulse_encoder_if.master        bus
);

    logic [NUM_LINES-1:0] req_vec;
    logic [NUM_LINES-1:0] nz_vec;
    logic [NUM_LINES-1:0] drop_vec;
    logic [NUM_LINES-1:0] dec_vec;
    logic                 any_nz;
    logic                 load;
    idx_t                 start_idx;
    idx_t                 winner;

    state_e state_q;
    idx_t   addr_q;
    logic   ovf_q;

    assign req_vec = {bus.req3, bus.req2, bus.req1, bus.req0};

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            assign dec_vec[gi] = load && (winner == idx_t'(gi));

            pulse_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc_i     (req_vec[gi]),
                .dec_i     (dec_vec[gi]),
                .nonzero_o (nz_vec[gi]),
                .drop_o    (drop_vec[gi])
            );
        end
    endgenerate

    assign any_nz = |nz_vec;

    // A new winner is loaded from idle, or in HOLD on the accepting edge (no bubble).
    assign load = any_nz && ((state_q == ST_IDLE) || bus.ready);

`ifdef PULSE_ENCODER_RR_EN
    idx_t ptr_q;

    assign start_idx = ptr_q + idx_t'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= idx_t'(3);
        end else if (load) begin
            ptr_q <= winner;
        end
    end
`else
    assign start_idx = '0;
`endif

    assign winner = pick_winner(nz_vec, start_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (|drop_vec);
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        state_q <= ST_HOLD;
                        addr_q  <= winner;
                    end
                end
                ST_HOLD: begin
                    if (bus.ready) begin
                        if (any_nz) begin
                            addr_q <= winner;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.enable = (state_q == ST_HOLD);
    assign bus.addr0  = addr_q[0];
    assign bus.addr1  = addr_q[1];
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_pulse_encoder.sv
// Directed scoreboard bench for pulse_encoder; expected order follows PULSE_ENCODER_RR_EN.
module tb_pulse_encoder;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_q[$];

    pulse_encoder_if bus();

    pulse_encoder #(
        .CNT_W (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic set_req(input logic [3:0] m);
        bus.req0 = m[0];
        bus.req1 = m[1];
        bus.req2 = m[2];
        bus.req3 = m[3];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int cur_addr();
        return int'({bus.addr1, bus.addr0});
    endfunction

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        #1;
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle_after"}, int'(bus.enable), 0);
    endtask

    // Monitor: a transfer completes on the next rising edge when enable and ready are high.
    initial begin
        int a;
        int e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.enable === 1'b1 && bus.ready === 1'b1) begin
                a = cur_addr();
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_txn actual=%0d required=none t=%0t", a, $time);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn addr=%0d expected=%0d t=%0t", a, e, $time);
                    check("txn_addr", a, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.ready = 1'b0;
        set_req(4'h0);

        // Reset held: toggling requests must not disturb anything.
        for (int i = 0; i < 4; i++) begin
            set_req((i % 2 == 0) ? 4'hF : 4'h0);
            step();
            check("rst_enable", int'(bus.enable), 0);
            check("rst_addr", cur_addr(), 0);
            check("rst_ovf", int'(bus.ovf), 0);
        end
        set_req(4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle_after_rst", int'(bus.enable), 0);
        end

        // Single pulse on line 2: enable two edges after the sampling edge.
        bus.ready = 1'b1;
        set_req(4'b0100);
        exp_q.push_back(2);
        step();
        set_req(4'h0);
        check("single_e1_enable", int'(bus.enable), 0);
        step();
        check("single_e2_enable", int'(bus.enable), 1);
        check("single_e2_addr", cur_addr(), 2);
        step();
        check("single_e3_enable", int'(bus.enable), 0);

        // All four lines pulsed for three edges.
`ifdef PULSE_ENCODER_RR_EN
        for (int r = 0; r < 3; r++)
            for (int l = 0; l < 4; l++) exp_q.push_back(l);
`else
        for (int l = 0; l < 4; l++)
            for (int r = 0; r < 3; r++) exp_q.push_back(l);
`endif
        set_req(4'hF);
        step();
        step();
        step();
        set_req(4'h0);
        check("rr_no_bubble", int'(bus.enable), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("rr_no_bubble", int'(bus.enable), 1);
        end
        drain("rr", 20);

        // Line 3 pulsing every cycle while the consumer accepts every cycle.
        set_req(4'b1000);
        for (int i = 0; i < 10; i++) exp_q.push_back(3);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i >= 2) begin
                check("sim_enable", int'(bus.enable), 1);
                check("sim_addr", cur_addr(), 3);
            end
        end
        set_req(4'h0);
        check("sim_ovf", int'(bus.ovf), 0);
        drain("sim", 20);

        // Stall with ten pulses on line 1: one loaded plus seven counted, two dropped.
        bus.ready = 1'b0;
        set_req(4'b0010);
        for (int i = 0; i < 8; i++) exp_q.push_back(1);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i >= 2) check("stall_addr", cur_addr(), 1);
        end
        set_req(4'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ovf", int'(bus.ovf), 1);
            check("stall_enable", int'(bus.enable), 1);
            check("stall_addr_frozen", cur_addr(), 1);
        end
        bus.ready = 1'b1;
        drain("sat", 20);
        check("ovf_sticky", int'(bus.ovf), 1);

        // Reset mid-transaction with events still pending.
        bus.ready = 1'b0;
        set_req(4'hF);
        step();
        step();
        set_req(4'h0);
        step();
        check("pre_rst_enable", int'(bus.enable), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_enable", int'(bus.enable), 0);
        check("midrst_addr", cur_addr(), 0);
        check("midrst_ovf", int'(bus.ovf), 0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        bus.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_stale_enable", int'(bus.enable), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
